// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage.
// Holds the ctrl_mem field layout and the memory command encoding.
package mem_stage_pkg;

    localparam int CTRL_W     = 5;
    localparam int MEM_CMD_HI = 4;
    localparam int MEM_CMD_LO = 3;
    localparam int WB_HI      = 2;
    localparam int WB_LO      = 0;
    localparam int MEM_CMD_W  = MEM_CMD_HI - MEM_CMD_LO + 1;
    localparam int WB_W       = WB_HI - WB_LO + 1;

    typedef enum logic [MEM_CMD_W-1:0] {
        MEM_NONE  = 2'b00,
        MEM_STORE = 2'b01,
        MEM_LOAD  = 2'b10
    } mem_cmd_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register set.
// Async active-low clear; loads every rising edge.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [WB_W-1:0] ctrl_d,
    input  logic [XLEN-1:0] rd_d,
    input  logic [XLEN-1:0] pc4_d,
    input  logic [XLEN-1:0] mem_d,
    input  logic [XLEN-1:0] alu_d,
    output logic [WB_W-1:0] ctrl_q,
    output logic [XLEN-1:0] rd_q,
    output logic [XLEN-1:0] pc4_q,
    output logic [XLEN-1:0] mem_q,
    output logic [XLEN-1:0] alu_q
);

    // Capture the whole bundle each edge; reset wipes it at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
            rd_q   <= '0;
            pc4_q  <= '0;
            mem_q  <= '0;
            alu_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
            pc4_q  <= pc4_d;
            mem_q  <= mem_d;
            alu_q  <= alu_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage.
// Drives data memory combinationally and registers results for WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CTRL_W-1:0]    ctrl_mem,
    input  logic [XLEN-1:0]      rd_mem,
    input  logic [XLEN-1:0]      pc4_mem,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      write_data1,
    input  logic [XLEN-1:0]      read_data,
    output logic [WB_W-1:0]      ctrl_wb,
    output logic [XLEN-1:0]      rd_wb,
    output logic [XLEN-1:0]      pc4_wb,
    output logic [XLEN-1:0]      mem_data,
    output logic [XLEN-1:0]      alu_data,
    output logic [MEM_CMD_W-1:0] mem_ctrl_input,
    output logic [XLEN-1:0]      address,
    output logic [XLEN-1:0]      w_data
);

    // Memory interface is pure wiring; reset never touches it.
    always_comb begin
        mem_ctrl_input = ctrl_mem[MEM_CMD_HI:MEM_CMD_LO];
        address        = alu_result;
        w_data         = write_data1;
    end

    mem_wb_reg #(
        .XLEN(XLEN)
    ) u_mem_wb_reg (
        .clk    (clk),
        .reset_n(reset_n),
        .ctrl_d (ctrl_mem[WB_HI:WB_LO]),
        .rd_d   (rd_mem),
        .pc4_d  (pc4_mem),
        .mem_d  (read_data),
        .alu_d  (alu_result),
        .ctrl_q (ctrl_wb),
        .rd_q   (rd_wb),
        .pc4_q  (pc4_wb),
        .mem_q  (mem_data),
        .alu_q  (alu_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Directed steps then randomized cycles against a reference model.
module tb_mem_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [4:0]      ctrl_mem;
    logic [XLEN-1:0] rd_mem;
    logic [XLEN-1:0] pc4_mem;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data1;
    logic [XLEN-1:0] read_data;
    logic [2:0]      ctrl_wb;
    logic [XLEN-1:0] rd_wb;
    logic [XLEN-1:0] pc4_wb;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] alu_data;
    logic [1:0]      mem_ctrl_input;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] w_data;

    int checks = 0;
    int errors = 0;

    // Reference model: what WB should currently show.
    logic [2:0]      e_ctrl;
    logic [XLEN-1:0] e_rd;
    logic [XLEN-1:0] e_pc4;
    logic [XLEN-1:0] e_mem;
    logic [XLEN-1:0] e_alu;

    mem_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ctrl_mem      (ctrl_mem),
        .rd_mem        (rd_mem),
        .pc4_mem       (pc4_mem),
        .alu_result    (alu_result),
        .write_data1   (write_data1),
        .read_data     (read_data),
        .ctrl_wb       (ctrl_wb),
        .rd_wb         (rd_wb),
        .pc4_wb        (pc4_wb),
        .mem_data      (mem_data),
        .alu_data      (alu_data),
        .mem_ctrl_input(mem_ctrl_input),
        .address       (address),
        .w_data        (w_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_clear();
        e_ctrl = '0;
        e_rd   = '0;
        e_pc4  = '0;
        e_mem  = '0;
        e_alu  = '0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".ctrl_wb"}, XLEN'(ctrl_wb), XLEN'(e_ctrl));
        chk({tag, ".rd_wb"}, rd_wb, e_rd);
        chk({tag, ".pc4_wb"}, pc4_wb, e_pc4);
        chk({tag, ".mem_data"}, mem_data, e_mem);
        chk({tag, ".alu_data"}, alu_data, e_alu);
    endtask

    task automatic chk_comb(input string tag);
        chk({tag, ".cmd"}, XLEN'(mem_ctrl_input), XLEN'(ctrl_mem[4:3]));
        chk({tag, ".address"}, address, alu_result);
        chk({tag, ".w_data"}, w_data, write_data1);
    endtask

    // One rising edge: the stage should show what was presented.
    task automatic step();
        @(posedge clk);
        if (reset_n) begin
            e_ctrl = ctrl_mem[2:0];
            e_rd   = rd_mem;
            e_pc4  = pc4_mem;
            e_mem  = read_data;
            e_alu  = alu_result;
        end else begin
            model_clear();
        end
        #1;
    endtask

    initial begin
        model_clear();
        reset_n     = 1'b0;
        ctrl_mem    = 5'b01111;
        alu_result  = 48;
        write_data1 = 40;
        rd_mem      = 20;
        pc4_mem     = 56;
        read_data   = 2;
        #1;
        chk_regs("rst_pre_edge");
        chk("rst_cmd", XLEN'(mem_ctrl_input), XLEN'(2'b01));
        chk("rst_addr", address, 48);
        chk("rst_wdata", w_data, 40);
        step();
        step();
        chk_regs("rst_held");

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_regs("release_wait");
        step();
        chk("store.ctrl", XLEN'(ctrl_wb), XLEN'(3'b111));
        chk("store.pc4", pc4_wb, 56);
        chk("store.alu", alu_data, 48);
        chk("store.rd", rd_wb, 20);
        chk("store.mem", mem_data, 2);

        @(negedge clk);
        ctrl_mem   = 5'b00101;
        pc4_mem    = 52;
        alu_result = 44;
        rd_mem     = 16;
        read_data  = 1;
        #1;
        chk("none.cmd", XLEN'(mem_ctrl_input), XLEN'(2'b00));
        chk("none.hold", XLEN'(ctrl_wb), XLEN'(3'b111));
        step();
        chk("none.ctrl", XLEN'(ctrl_wb), XLEN'(3'b101));
        chk("none.pc4", pc4_wb, 52);
        chk("none.alu", alu_data, 44);
        chk("none.rd", rd_wb, 16);
        chk("none.mem", mem_data, 1);

        @(negedge clk);
        ctrl_mem  = 5'b10110;
        read_data = 32'hdead_beef;
        step();
        chk_regs("load");
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk_regs("load_rst");
        chk("load_rst.cmd", XLEN'(mem_ctrl_input), XLEN'(2'b10));
        step();
        chk_regs("load_rst_edge");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_regs("load_rel_wait");
        step();
        chk("load_rel.ctrl", XLEN'(ctrl_wb), XLEN'(3'b110));
        chk("load_rel.mem", mem_data, 32'hdead_beef);

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            reset_n     = 1'b1;
            ctrl_mem    = 5'($urandom);
            rd_mem      = $urandom;
            pc4_mem     = $urandom;
            alu_result  = $urandom;
            write_data1 = $urandom;
            read_data   = $urandom;
            #1;
            chk_comb("rnd_comb");
            chk_regs("rnd_hold");
            if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                model_clear();
                #1;
                chk_regs("rnd_rst");
                chk_comb("rnd_rst_comb");
            end
            step();
            chk_regs("rnd_edge");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width of all 32-bit ports.
REQ-002 clk  input  1  pipeline clock, rising-edge active.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ctrl_mem  input  5  control bundle: [4:3] memory command, [2:0] writeback control.
REQ-005 rd_mem  input  XLEN  destination-register tag from the EX/MEM stage.
REQ-006 pc4_mem  input  XLEN  PC+4 of the instruction in MEM.
REQ-007 alu_result  input  XLEN  ALU result; used as memory address and forwarded to WB.
REQ-008 write_data1  input  XLEN  store data.
REQ-009 read_data  input  XLEN  data returned by external data memory.
REQ-010 ctrl_wb  output  3  registered writeback control.
REQ-011 rd_wb  output  XLEN  registered rd tag.
REQ-012 pc4_wb  output  XLEN  registered PC+4.
REQ-013 mem_data  output  XLEN  registered memory read data.
REQ-014 alu_data  output  XLEN  registered ALU result.
REQ-015 mem_ctrl_input  output  2  memory command to data memory: 00 none, 01 store, 10 load, 11 reserved (treated as none).
REQ-016 address  output  XLEN  data-memory address.
REQ-017 w_data  output  XLEN  data-memory write data.

Function
REQ-018 mem_ctrl_input SHALL equal ctrl_mem[4:3] combinationally, independent of clk and reset_n.
REQ-019 address SHALL equal alu_result combinationally, independent of reset_n.
REQ-020 w_data SHALL equal write_data1 combinationally, independent of reset_n.
REQ-021 On each rising clk edge with reset_n=1: ctrl_wb<=ctrl_mem[2:0], rd_wb<=rd_mem, pc4_wb<=pc4_mem, mem_data<=read_data, alu_data<=alu_result.
REQ-022 Registered outputs SHALL have exactly one cycle of latency; there is no handshake, stall, or enable.
REQ-023 mem_data SHALL capture read_data as presented at the clock edge, whatever the command; the memory read is combinational within the cycle.
REQ-024 No arithmetic is performed; all values pass through bit-exact with no sign or width change.

Reset
REQ-025 reset_n=0 SHALL immediately clear ctrl_wb, rd_wb, pc4_wb, mem_data and alu_data to 0, without waiting for a clock edge.
REQ-026 Registered outputs SHALL hold 0 while reset_n=0, and after deassertion until the first rising clk edge.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight stage contents, with no partial update.
REQ-028 Reset SHALL NOT affect the combinational outputs mem_ctrl_input, address and w_data.

Structure
REQ-029 A shared package SHALL hold the ctrl_mem field positions ([4:3] memory command, [2:0] writeback control) and the memory-command constants MEM_NONE=00, MEM_STORE=01, MEM_LOAD=10.
REQ-030 One sub-module, mem_wb_reg, SHALL implement the asynchronously reset MEM/WB register set; the combinational memory interface SHALL stay in the top module.

Verification
REQ-031 Reset held, then ctrl_mem=01111, alu_result=48, write_data1=40 -> before any edge: all registered outputs 0, mem_ctrl_input=01, address=48, w_data=40.
REQ-032 Store: ctrl_mem=01111, pc4_mem=56, alu_result=48, rd_mem=20, read_data=2, then one edge -> ctrl_wb=111, pc4_wb=56, alu_data=48, rd_wb=20, mem_data=2.
REQ-033 Then ctrl_mem=00101, pc4_mem=52, alu_result=44, rd_mem=16, read_data=1, then one edge -> mem_ctrl_input=00 immediately; after the edge ctrl_wb=101, pc4_wb=52, alu_data=44, rd_wb=16, mem_data=1.
REQ-034 Load: ctrl_mem=10110, then reset_n=0 between edges -> registered outputs 0 at once, mem_ctrl_input stays 10.
REQ-035 Release reset_n between edges -> registered outputs stay 0 until the next rising edge, then load the current inputs.
REQ-036 Per cycle: check address and w_data track alu_result and write_data1 within the same cycle.
